// File: rtl/pulse_stim_pkg.sv
// pulse_stim_pkg: shared types and constants for the pulse stimulus generator.
//   state_t          - generator state encoding
//   BASELINE_DEFAULT - idle/mean sample level
//   SHIFT_DEFAULT    - recovery divisor exponent (step = ceil(dist / 2^SHIFT))
//   GAP_W_DEFAULT    - width of the inter-pulse gap counter
//   LFSR_SEED/TAPS   - dither LFSR constants (used only with PULSE_STIM_NOISE_EN)
package pulse_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    FALL,
    RECOVER,
    DONE
  } state_t;

  localparam logic [7:0] BASELINE_DEFAULT = 8'd122;
  localparam int         SHIFT_DEFAULT    = 3;
  localparam int         GAP_W_DEFAULT    = 10;

  // Taps 8,6,5,4 of a maximal-length 8-bit Fibonacci LFSR -> bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/pulse_stim_gen_if.sv
// pulse_stim_gen_if: control and sample-stream bundle of the pulse generator.
//   enable/start/stop, amplitude, gap, pulse_count : controller -> generator
//   dout, dout_valid, pk_mark, busy, done           : generator -> consumer
// Modports: master (controller / consumer side), slave (generator side).
interface pulse_stim_gen_if #(
  parameter int GAP_W = 10
);
  logic             enable;
  logic             start;
  logic             stop;
  logic [7:0]       amplitude;
  logic [GAP_W-1:0] gap;
  logic [7:0]       pulse_count;
  logic [7:0]       dout;
  logic             dout_valid;
  logic             pk_mark;
  logic             busy;
  logic             done;

  modport master (
    output enable, start, stop, amplitude, gap, pulse_count,
    input  dout, dout_valid, pk_mark, busy, done
  );

  modport slave (
    input  enable, start, stop, amplitude, gap, pulse_count,
    output dout, dout_valid, pk_mark, busy, done
  );
endinterface

// File: rtl/pulse_lfsr8.sv
// pulse_lfsr8: 8-bit maximal Fibonacci LFSR used to dither generator samples.
// The module exists only when PULSE_STIM_NOISE_EN is defined; the default
// build has no dither source.
//   clk     - clock
//   rst     - synchronous active-high reset, loads LFSR_SEED
//   advance - shift one step on this cycle
//   state   - current LFSR contents
`ifdef PULSE_STIM_NOISE_EN
module pulse_lfsr8
  import pulse_stim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] state
);
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;
endmodule
`endif

// File: rtl/pulse_stim_gen.sv
// pulse_stim_gen: synthetic ADC sample source producing negative-going pulses
// (one-sample drop, exponential-style recovery) on a fixed baseline.
//   clk - clock
//   rst - synchronous active-high reset
//   bus - pulse_stim_gen_if.slave: enable/start/stop/amplitude/gap/pulse_count
//         in; dout/dout_valid/pk_mark/busy/done out (all registered)
// Optional: define PULSE_STIM_NOISE_EN to add +/-1 LFSR dither in GAP and
// RECOVER samples.
module pulse_stim_gen
  import pulse_stim_pkg::*;
#(
  parameter logic [7:0] BASELINE = BASELINE_DEFAULT,
  parameter int         SHIFT    = SHIFT_DEFAULT,
  parameter int         GAP_W    = GAP_W_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  pulse_stim_gen_if.slave bus
);
  state_t           state_q, state_d;
  logic [7:0]       cur_q, cur_d;          // undithered waveform value
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             pk_mark_q, pk_mark_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic [7:0]       amp_q, amp_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [GAP_W-1:0] gap_cnt_inc;
  logic [7:0]       fall_low;
  logic [8:0]       rec_step;
  logic [8:0]       rec_sum;
  logic [7:0]       rec_next;
  logic             pulse_end;

`ifdef PULSE_STIM_NOISE_EN
  logic [7:0] lfsr_state;

  pulse_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(bus.enable),
    .state  (lfsr_state)
  );

  function automatic logic [7:0] dither(input logic [7:0] v);
    case (lfsr_state[1:0])
      2'b01:   return (v == 8'd255) ? v : v + 8'd1;
      2'b10:   return (v == 8'd0)   ? v : v - 8'd1;
      default: return v;
    endcase
  endfunction
`else
  function automatic logic [7:0] dither(input logic [7:0] v);
    return v;
  endfunction
`endif

  assign gap_cnt_inc = gap_cnt_q + GAP_W'(1);
  assign fall_low    = (amp_q > BASELINE) ? 8'd0 : BASELINE - amp_q;

  // Rounded-up step keeps progress >= 1 until cur reaches BASELINE; 9 bits
  // hold the biased distance, and the clamp keeps the sum at or below it.
  assign rec_step = ({1'b0, BASELINE} - {1'b0, cur_q} + 9'((1 << SHIFT) - 1)) >> SHIFT;
  assign rec_sum  = {1'b0, cur_q} + rec_step;
  assign rec_next = (rec_sum > {1'b0, BASELINE}) ? BASELINE : rec_sum[7:0];

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    pk_mark_d    = 1'b0;
    done_d       = 1'b0;
    gap_cnt_d    = gap_cnt_q;
    pcnt_d       = pcnt_q;
    amp_d        = amp_q;
    gap_d        = gap_q;
    cnt_d        = cnt_q;
    pulse_end    = 1'b0;

    if (bus.stop) begin
      state_d   = IDLE;
      cur_d     = BASELINE;
      dout_d    = BASELINE;
      gap_cnt_d = '0;
      pcnt_d    = '0;
    end else if (state_q == DONE) begin
      // Not gated by enable: done is a control pulse, not a sample.
      done_d    = 1'b1;
      state_d   = IDLE;
      gap_cnt_d = '0;
      pcnt_d    = '0;
    end else if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          cur_d  = BASELINE;
          dout_d = BASELINE;
          if (bus.start) begin
            amp_d     = bus.amplitude;
            gap_d     = bus.gap;
            cnt_d     = bus.pulse_count;
            gap_cnt_d = '0;
            pcnt_d    = '0;
            state_d   = GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_d = FALL;
          end else begin
            dout_d       = dither(BASELINE);
            dout_valid_d = 1'b1;
            if (gap_cnt_inc == gap_q) begin
              gap_cnt_d = '0;
              state_d   = FALL;
            end else begin
              gap_cnt_d = gap_cnt_inc;
            end
          end
        end
        FALL: begin
          cur_d        = fall_low;
          dout_d       = fall_low;
          dout_valid_d = 1'b1;
          pk_mark_d    = 1'b1;
          if (fall_low == BASELINE) pulse_end = 1'b1;
          else                      state_d   = RECOVER;
        end
        RECOVER: begin
          cur_d        = rec_next;
          dout_d       = dither(rec_next);
          dout_valid_d = 1'b1;
          if (rec_next == BASELINE) pulse_end = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // Counter wraps naturally at 255 in continuous mode (cnt_q == 0).
      if (pulse_end) begin
        pcnt_d = pcnt_q + 8'd1;
        if (cnt_q != 8'd0 && pcnt_d == cnt_q) state_d = DONE;
        else                                  state_d = GAP;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= BASELINE;
      dout_q       <= BASELINE;
      dout_valid_q <= 1'b0;
      pk_mark_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      gap_cnt_q    <= '0;
      pcnt_q       <= '0;
      amp_q        <= '0;
      gap_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      pk_mark_q    <= pk_mark_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      gap_cnt_q    <= gap_cnt_d;
      pcnt_q       <= pcnt_d;
      amp_q        <= amp_d;
      gap_q        <= gap_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.pk_mark    = pk_mark_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_pulse_stim_gen.sv
// tb_pulse_stim_gen: self-checking bench for pulse_stim_gen. Expected sample
// streams come from a burst-level model built with plain arithmetic.
module tb_pulse_stim_gen;
  typedef struct packed {
    logic [7:0] v;
    logic       pk;
  } samp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks_total  = 0;
  int   checks_passed = 0;
  samp_t exp_q[$];
  samp_t got_q[$];

  always #5 clk = ~clk;

  pulse_stim_gen_if #(.GAP_W(10)) bus ();

  pulse_stim_gen #(
    .BASELINE(8'd122),
    .SHIFT   (3),
    .GAP_W   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected valid-sample stream of one finite burst.
  task automatic build_model(input int amp, input int gap, input int cnt);
    int    low;
    int    cur;
    samp_t s;
    exp_q.delete();
    for (int p = 0; p < cnt; p++) begin
      for (int g = 0; g < gap; g++) begin
        s.v = 8'd122; s.pk = 1'b0; exp_q.push_back(s);
      end
      low = (amp > 122) ? 0 : 122 - amp;
      s.v = 8'(low); s.pk = 1'b1; exp_q.push_back(s);
      cur = low;
      while (cur < 122) begin
        cur = cur + (122 - cur + 7) / 8;
        if (cur > 122) cur = 122;
        s.v = 8'(cur); s.pk = 1'b0; exp_q.push_back(s);
      end
    end
  endtask

  // Starts a burst and collects samples until done. Every cycle whose edge
  // saw enable=0 is checked for a held dout and deasserted strobes.
  task automatic run_burst(input int amp, input int gap, input int cnt,
                           input bit rand_en, output int done_cnt);
    logic [7:0] prev_dout;
    bit         en_applied;
    bit         finished;
    samp_t      s;
    got_q.delete();
    done_cnt = 0;
    finished = 0;
    @(negedge clk);
    bus.amplitude   = 8'(amp);
    bus.gap         = 10'(gap);
    bus.pulse_count = 8'(cnt);
    bus.start       = 1'b1;
    bus.enable      = 1'b1;
    en_applied      = 1'b1;
    prev_dout       = bus.dout;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge clk);
      if (!en_applied) begin
        checks_total++;
        if (bus.dout !== prev_dout || bus.dout_valid !== 1'b0 || bus.pk_mark !== 1'b0)
          $display("FAIL hold: dout=%0d valid=%0b pk=%0b, required dout=%0d valid=0 pk=0",
                   bus.dout, bus.dout_valid, bus.pk_mark, prev_dout);
        else checks_passed++;
      end
      if (bus.dout_valid) begin
        s.v = bus.dout; s.pk = bus.pk_mark; got_q.push_back(s);
      end
      if (bus.done) begin
        done_cnt++;
        finished = 1;
        checks_total++;
        if (bus.busy !== 1'b0) $display("FAIL busy_at_done: busy=%0b required 0", bus.busy);
        else checks_passed++;
      end
      prev_dout  = bus.dout;
      bus.start  = 1'b0;
      en_applied = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.enable = en_applied;
    end
    checks_total++;
    if (!finished) $display("FAIL burst_timeout: no done within cycle budget, required done");
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL done_width: done=%0b busy=%0b required 0 0", bus.done, bus.busy);
    else checks_passed++;
    bus.enable = 1'b1;
    $display("burst amp=%0d gap=%0d cnt=%0d rand_en=%0b samples=%0d done=%0d",
             amp, gap, cnt, rand_en, got_q.size(), done_cnt);
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = -1;
    checks_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s_len: got %0d samples required %0d", name, got_q.size(), exp_q.size());
    else checks_passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks_total++;
    if (bad >= 0)
      $display("FAIL %s_seq: idx %0d got %0d/pk%0b required %0d/pk%0b", name, bad,
               got_q[bad].v, got_q[bad].pk, exp_q[bad].v, exp_q[bad].pk);
    else checks_passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.enable = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.amplitude = 8'd0; bus.gap = 10'd0; bus.pulse_count = 8'd0;
    repeat (3) @(negedge clk);
    checks_total++;
    if (bus.dout !== 8'd122 || bus.dout_valid !== 1'b0 || bus.pk_mark !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset: dout=%0d valid=%0b pk=%0b busy=%0b done=%0b required 122 0 0 0 0",
               bus.dout, bus.dout_valid, bus.pk_mark, bus.busy, bus.done);
    else checks_passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks_total++;
    if (bus.dout !== 8'd122 || bus.busy !== 1'b0)
      $display("FAIL idle_after_reset: dout=%0d busy=%0b required 122 0", bus.dout, bus.busy);
    else checks_passed++;
  endtask

  task automatic test_single_pulse;
    int dn;
    int want[5] = '{72, 79, 85, 90, 94};
    build_model(50, 4, 1);
    run_burst(50, 4, 1, 1'b0, dn);
    compare_stream("single");
    for (int i = 0; i < 5; i++) begin
      checks_total++;
      if (got_q.size() <= 4 + i || got_q[4 + i].v !== 8'(want[i]))
        $display("FAIL single_val%0d: got %0d required %0d", i,
                 (got_q.size() > 4 + i) ? int'(got_q[4 + i].v) : -1, want[i]);
      else checks_passed++;
    end
    checks_total++;
    if (got_q.size() < 5 || got_q[3].pk !== 1'b0 || got_q[4].pk !== 1'b1)
      $display("FAIL single_latency: pk_mark not on sample index 4 (gap+1-th)");
    else checks_passed++;
  endtask

  task automatic test_multi_burst;
    int dn;
    int pks;
    int bad_pk;
    build_model(20, 2, 3);
    run_burst(20, 2, 3, 1'b0, dn);
    compare_stream("multi");
    pks = 0; bad_pk = 0;
    foreach (got_q[i]) if (got_q[i].pk) begin
      pks++;
      if (got_q[i].v !== 8'd102) bad_pk++;
    end
    checks_total++;
    if (pks != 3 || bad_pk != 0)
      $display("FAIL multi_pk: got %0d marks (%0d not 102) required 3 marks at 102", pks, bad_pk);
    else checks_passed++;
    checks_total++;
    if (dn != 1) $display("FAIL multi_done: got %0d done pulses required 1", dn);
    else checks_passed++;
  endtask

  task automatic test_deep_pulse;
    int dn;
    int mx;
    build_model(200, 0, 1);
    run_burst(200, 0, 1, 1'b0, dn);
    compare_stream("deep");
    checks_total++;
    if (got_q.size() < 3 || got_q[0] !== samp_t'({8'd0, 1'b1}) ||
        got_q[1].v !== 8'd16 || got_q[2].v !== 8'd30)
      $display("FAIL deep_head: first samples differ from 0/pk,16,30");
    else checks_passed++;
    mx = 0;
    foreach (got_q[i]) if (int'(got_q[i].v) > mx) mx = int'(got_q[i].v);
    checks_total++;
    if (mx != 122) $display("FAIL deep_max: got %0d required 122", mx);
    else checks_passed++;
  endtask

  task automatic test_enable_toggle;
    int dn;
    build_model(50, 4, 1);
    run_burst(50, 4, 1, 1'b1, dn);
    compare_stream("toggle");
  endtask

  task automatic test_flat_pulse;
    int dn;
    build_model(0, 1, 2);
    run_burst(0, 1, 2, 1'b0, dn);
    compare_stream("flat");
  endtask

  task automatic test_random;
    int dn;
    int amp, gap, cnt;
    for (int it = 0; it < 6; it++) begin
      amp = $urandom_range(0, 255);
      gap = $urandom_range(0, 5);
      cnt = $urandom_range(1, 3);
      build_model(amp, gap, cnt);
      run_burst(amp, gap, cnt, 1'($urandom_range(0, 1)), dn);
      compare_stream("random");
    end
  endtask

  task automatic test_stop;
    bit seen_pk;
    int extra_busy;
    int extra_done;
    seen_pk = 0;
    @(negedge clk);
    bus.amplitude = 8'd60; bus.gap = 10'd1; bus.pulse_count = 8'd0;
    bus.start = 1'b1; bus.enable = 1'b1;
    for (int c = 0; c < 50 && !seen_pk; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.pk_mark) seen_pk = 1;
    end
    checks_total++;
    if (!seen_pk) $display("FAIL stop_setup: no pk_mark within budget, required one");
    else checks_passed++;
    repeat (2) @(negedge clk);
    bus.stop = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0; bus.start = 1'b0;
    checks_total++;
    if (bus.busy !== 1'b0 || bus.dout !== 8'd122 || bus.done !== 1'b0 || bus.dout_valid !== 1'b0)
      $display("FAIL stop: busy=%0b dout=%0d done=%0b valid=%0b required 0 122 0 0",
               bus.busy, bus.dout, bus.done, bus.dout_valid);
    else checks_passed++;
    extra_busy = 0; extra_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) extra_busy++;
      if (bus.done !== 1'b0) extra_done++;
    end
    checks_total++;
    if (extra_busy != 0 || extra_done != 0)
      $display("FAIL stop_after: busy cycles=%0d done cycles=%0d required 0 0", extra_busy, extra_done);
    else checks_passed++;
  endtask

  task automatic test_reset_mid;
    int gaps;
    int dn;
    gaps = 0;
    @(negedge clk);
    bus.amplitude = 8'd50; bus.gap = 10'd3; bus.pulse_count = 8'd1;
    bus.start = 1'b1; bus.enable = 1'b1;
    for (int c = 0; c < 20 && gaps < 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.dout_valid) gaps++;
    end
    checks_total++;
    if (gaps != 3) $display("FAIL rst_mid_setup: got %0d gap samples required 3", gaps);
    else checks_passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks_total++;
    if (bus.dout !== 8'd122 || bus.pk_mark !== 1'b0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0)
      $display("FAIL rst_mid: dout=%0d pk=%0b busy=%0b valid=%0b required 122 0 0 0",
               bus.dout, bus.pk_mark, bus.busy, bus.dout_valid);
    else checks_passed++;
    build_model(50, 3, 1);
    run_burst(50, 3, 1, 1'b0, dn);
    compare_stream("replay");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_multi_burst();
    test_deep_pulse();
    test_enable_toggle();
    test_flat_pulse();
    test_random();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
